r2r_dac_wave_sequencer: RTL and testbench

//  Sample-rate scheduler feeding the 8-bit R2R DAC code bus ahead of the dac_drive level shifters.

---
 rtl/r2r_dac_pkg.sv | 29 ++
 rtl/r2r_sample_fifo.sv | 64 ++++++
 rtl/r2r_dac_wave_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_r2r_dac_wave_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/r2r_dac_pkg.sv
// Shared types and constants for the R2R DAC waveform sequencer.
package r2r_dac_pkg;

    localparam int DAC_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_RAMP = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_FIFO = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Triangle direction for the next step; each endpoint is emitted once before turning.
    function automatic logic tri_step_up(input logic dir_up, input logic at_max, input logic at_zero);
        logic up_s;
        if (dir_up) begin
            up_s = !at_max;
        end else begin
            up_s = at_zero;
        end
        return up_s;
    endfunction

endpackage

// File: rtl/r2r_sample_fifo.sv
// Synchronous sample FIFO; flush overrides push and pop, full blocks push even during a pop.
module r2r_sample_fifo
    import r2r_dac_pkg::*;
#(
    parameter  int W     = DAC_W_DEF,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == {LW{1'b0}});
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;
    assign head_data = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Sample storage; contents are don't-care until the pointers make them visible.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/r2r_dac_wave_sequencer.sv
// Sample-rate scheduler producing a registered, glitch-free R2R DAC code from
// a held value, ramp, triangle or sample FIFO on each divider tick.
module r2r_dac_wave_sequencer
    import r2r_dac_pkg::*;
#(
    parameter  int DAC_W       = DAC_W_DEF,
    parameter  int DIV_W       = 16,
    parameter  int DIV_DEFAULT = 999,
    parameter  int FIFO_DEPTH  = 16,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic [1:0]       mode,
    input  logic [DAC_W-1:0] direct_data,
    input  logic             start,
    input  logic             stop,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [DAC_W-1:0] wr_data,
    output logic             wr_ready,
    output logic [DAC_W-1:0] dac_code,
    output logic             sample_strobe,
    output logic             busy,
    output logic             underrun,
    output logic [LVL_W-1:0] fifo_level
);

    localparam logic [DAC_W-1:0] CODE_MAX  = {DAC_W{1'b1}};
    localparam logic [DAC_W-1:0] CODE_ZERO = {DAC_W{1'b0}};

    state_e           state_r;
    state_e           state_nxt_s;
    mode_e            mode_r;
    logic [DIV_W-1:0] div_reg_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DAC_W-1:0] acc_r;
    logic             dir_up_r;
    logic [DAC_W-1:0] dac_code_r;
    logic             strobe_r;
    logic             underrun_r;

    logic             start_acc_s;
    logic             tick_s;
    logic [DAC_W-1:0] acc_nxt_s;
    logic             dir_nxt_s;
    logic [DAC_W-1:0] code_nxt_s;
    logic             underrun_set_s;
    logic             tri_up_s;
    logic             fifo_pop_s;
    logic [DAC_W-1:0] fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    r2r_sample_fifo #(
        .W     (DAC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop_s),
        .flush     (flush),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    // A stop in the tick cycle suppresses the update so the code freezes at the last emitted value.
    assign tick_s = (state_r == ST_RUN) && !stop && (div_cnt_r == {DIV_W{1'b0}});

    // Run-control next state; stop dominates start.
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt_s = ST_RUN;
                    start_acc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Waveform generation and FIFO pop for the current tick.
    always_comb begin
        acc_nxt_s      = acc_r;
        dir_nxt_s      = dir_up_r;
        code_nxt_s     = dac_code_r;
        underrun_set_s = 1'b0;
        fifo_pop_s     = 1'b0;
        tri_up_s       = tri_step_up(dir_up_r, acc_r == CODE_MAX, acc_r == CODE_ZERO);
        if (tick_s) begin
            case (mode_r)
                MODE_HOLD: code_nxt_s = direct_data;
                MODE_RAMP: begin
                    acc_nxt_s  = acc_r + DAC_W'(1);
                    code_nxt_s = acc_r + DAC_W'(1);
                end
                MODE_TRI: begin
                    dir_nxt_s  = tri_up_s;
                    acc_nxt_s  = tri_up_s ? (acc_r + DAC_W'(1)) : (acc_r - DAC_W'(1));
                    code_nxt_s = tri_up_s ? (acc_r + DAC_W'(1)) : (acc_r - DAC_W'(1));
                end
                MODE_FIFO: begin
                    if (fifo_empty_s) begin
                        underrun_set_s = 1'b1;
                    end else begin
                        fifo_pop_s = 1'b1;
                        code_nxt_s = fifo_head_s;
                    end
                end
                default: code_nxt_s = dac_code_r;
            endcase
        end else begin
            code_nxt_s = dac_code_r;
        end
    end

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample divider; a load applies immediately and the counter only moves while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg_r <= DIV_W'(DIV_DEFAULT);
            div_cnt_r <= DIV_W'(DIV_DEFAULT);
        end else if (div_load) begin
            div_reg_r <= div_value;
            div_cnt_r <= div_value;
        end else if (start_acc_s) begin
            div_cnt_r <= div_reg_r;
        end else if (state_r == ST_RUN) begin
            if (div_cnt_r == {DIV_W{1'b0}}) begin
                div_cnt_r <= div_reg_r;
            end else begin
                div_cnt_r <= div_cnt_r - DIV_W'(1);
            end
        end
    end

    // Mode latch and ramp/triangle accumulator, restarted on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= MODE_HOLD;
            acc_r    <= CODE_ZERO;
            dir_up_r <= 1'b1;
        end else if (start_acc_s) begin
            mode_r   <= mode_e'(mode);
            acc_r    <= CODE_ZERO;
            dir_up_r <= 1'b1;
        end else begin
            acc_r    <= acc_nxt_s;
            dir_up_r <= dir_nxt_s;
        end
    end

    // Registered DAC code, strobe and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code_r <= CODE_ZERO;
            strobe_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            dac_code_r <= code_nxt_s;
            strobe_r   <= tick_s;
            if (start_acc_s) begin
                underrun_r <= 1'b0;
            end else if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign dac_code      = dac_code_r;
    assign sample_strobe = strobe_r;
    assign underrun      = underrun_r;
    assign busy          = (state_r == ST_RUN);
    assign wr_ready      = !fifo_full_s;

endmodule

// File: tb/tb_r2r_dac_wave_sequencer.sv
// Directed self-checking bench for r2r_dac_wave_sequencer.
module tb_r2r_dac_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_load = 1'b0;
    logic [15:0] div_value = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  direct_data = 8'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_ready;
    logic [7:0]  dac_code;
    logic        sample_strobe;
    logic        busy;
    logic        underrun;
    logic [4:0]  fifo_level;

    int tests_run = 0;
    int tests_failed = 0;

    r2r_dac_wave_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .div_load      (div_load),
        .div_value     (div_value),
        .mode          (mode),
        .direct_data   (direct_data),
        .start         (start),
        .stop          (stop),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .dac_code      (dac_code),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .underrun      (underrun),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(input int max_cyc, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!sample_strobe && n < max_cyc);
        check_eq("strobe_seen", {31'd0, sample_strobe}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic load_div(input logic [15:0] v);
        div_load  = 1'b1;
        div_value = v;
        cyc(1);
        div_load  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        check_eq("push_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        int n;
        int exp_code;

        // Reset state
        cyc(3);
        check_eq("rst_code", {24'd0, dac_code}, 32'd0);
        check_eq("rst_strobe", {31'd0, sample_strobe}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("rst_ready", {31'd0, wr_ready}, 32'd1);
        check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
        rst = 1'b0;

        // Ramp with div 3: strobe every 4 clocks, 1..255 then 0, then 1
        load_div(16'd3);
        mode = 2'd1;
        pulse_start();
        check_eq("ramp_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 257; k++) begin
            wait_strobe(10, n);
            check_eq("ramp_period", n, 32'd4);
            check_eq("ramp_code", {24'd0, dac_code}, k % 256);
        end
        pulse_stop();
        check_eq("stop_busy", {31'd0, busy}, 32'd0);
        check_eq("stop_code", {24'd0, dac_code}, 32'd1);
        cyc(6);
        check_eq("idle_hold_code", {24'd0, dac_code}, 32'd1);
        check_eq("idle_no_strobe", {31'd0, sample_strobe}, 32'd0);

        // Triangle with div 0: 1..255, 254..0, 1
        load_div(16'd0);
        mode = 2'd2;
        pulse_start();
        wait_strobe(4, n);
        check_eq("tri_first_lat", n, 32'd1);
        check_eq("tri_code_1", {24'd0, dac_code}, 32'd1);
        for (int i = 2; i <= 511; i++) begin
            cyc(1);
            if (i <= 255) exp_code = i;
            else if (i <= 510) exp_code = 510 - i;
            else exp_code = i - 510;
            check_eq("tri_strobe", {31'd0, sample_strobe}, 32'd1);
            check_eq("tri_code", {24'd0, dac_code}, exp_code);
        end
        pulse_stop();
        check_eq("tri_stop_busy", {31'd0, busy}, 32'd0);
        check_eq("tri_stop_code", {24'd0, dac_code}, 32'd1);

        // FIFO playback then underrun
        push(8'h10);
        push(8'h20);
        push(8'h30);
        check_eq("fifo_level3", {27'd0, fifo_level}, 32'd3);
        load_div(16'd3);
        mode = 2'd3;
        pulse_start();
        wait_strobe(10, n);
        check_eq("fifo_lat", n, 32'd4);
        check_eq("fifo_code0", {24'd0, dac_code}, 32'h10);
        check_eq("fifo_level2", {27'd0, fifo_level}, 32'd2);
        wait_strobe(10, n);
        check_eq("fifo_code1", {24'd0, dac_code}, 32'h20);
        wait_strobe(10, n);
        check_eq("fifo_code2", {24'd0, dac_code}, 32'h30);
        check_eq("fifo_no_underrun", {31'd0, underrun}, 32'd0);
        wait_strobe(10, n);
        check_eq("underrun_period", n, 32'd4);
        check_eq("underrun_hold", {24'd0, dac_code}, 32'h30);
        check_eq("underrun_set", {31'd0, underrun}, 32'd1);
        pulse_stop();
        check_eq("underrun_sticky", {31'd0, underrun}, 32'd1);
        pulse_start();
        check_eq("underrun_clr", {31'd0, underrun}, 32'd0);
        pulse_stop();

        // Empty FIFO: push and tick in the same cycle
        load_div(16'd0);
        pulse_start();
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        cyc(1);
        wr_valid = 1'b0;
        check_eq("pt_strobe", {31'd0, sample_strobe}, 32'd1);
        check_eq("pt_underrun", {31'd0, underrun}, 32'd1);
        check_eq("pt_code_hold", {24'd0, dac_code}, 32'h30);
        check_eq("pt_level", {27'd0, fifo_level}, 32'd1);
        cyc(1);
        check_eq("pt_code_pop", {24'd0, dac_code}, 32'h5A);
        check_eq("pt_level0", {27'd0, fifo_level}, 32'd0);
        pulse_stop();

        // Fill to full, reject 17th write, flush
        for (int i = 0; i < 16; i++) push(8'(i * 3 + 1));
        check_eq("full_level", {27'd0, fifo_level}, 32'd16);
        check_eq("full_ready", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        cyc(1);
        wr_valid = 1'b0;
        check_eq("full_reject", {27'd0, fifo_level}, 32'd16);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check_eq("flush_level", {27'd0, fifo_level}, 32'd0);
        check_eq("flush_ready", {31'd0, wr_ready}, 32'd1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        cyc(1);
        flush    = 1'b0;
        wr_valid = 1'b0;
        check_eq("flush_beats_push", {27'd0, fifo_level}, 32'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("ss_idle_busy", {31'd0, busy}, 32'd0);

        // Reset during FIFO playback with five samples queued
        for (int i = 0; i < 5; i++) push(8'(8'h61 + i));
        load_div(16'd3);
        mode = 2'd3;
        pulse_start();
        cyc(1);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        check_eq("pre_rst_level", {27'd0, fifo_level}, 32'd5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_eq("mid_rst_code", {24'd0, dac_code}, 32'd0);
        check_eq("mid_rst_level", {27'd0, fifo_level}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, wr_ready}, 32'd1);

        // Default divider after reset, HOLD resampling and live div_load
        mode        = 2'd0;
        direct_data = 8'h77;
        pulse_start();
        wait_strobe(1100, n);
        check_eq("default_div", n, 32'd1000);
        check_eq("hold_code", {24'd0, dac_code}, 32'h77);
        direct_data = 8'h33;
        load_div(16'd1);
        wait_strobe(10, n);
        check_eq("live_div_lat", n, 32'd2);
        check_eq("hold_resample", {24'd0, dac_code}, 32'h33);
        direct_data = 8'h44;
        wait_strobe(10, n);
        check_eq("live_div_period", n, 32'd2);
        check_eq("hold_resample2", {24'd0, dac_code}, 32'h44);
        pulse_stop();
        check_eq("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
